// File: rtl/chimera_clu_iso_seq.sv
// Per-cluster isolation and clock-gating sequencer.
// Each cluster runs its own FSM. The FSM drains the cluster's AXI isolation
// ports, waits for them to report isolated, and then gates the cluster clock.
// On wake-up it restores the clock first and releases isolation afterwards.
module chimera_clu_iso_seq #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned GateDelay     = 4,
  parameter int unsigned WakeDelay     = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumClusters-1:0]          iso_req_i,
  input  logic [NumClusters*NumPorts-1:0] isolated_i,
  output logic [NumClusters*NumPorts-1:0] isolate_o,
  output logic [NumClusters-1:0]          clk_en_o,
  output logic [NumClusters-1:0]          iso_done_o,
  output logic [NumClusters-1:0]          timeout_o,
  input  logic [NumClusters-1:0]          timeout_clr_i,
  output logic [3*NumClusters-1:0]        state_o
);

  localparam int unsigned MaxTg    = (TimeoutCycles > GateDelay) ? TimeoutCycles : GateDelay;
  localparam int unsigned MaxDelay = (MaxTg > WakeDelay) ? MaxTg : WakeDelay;
  localparam int unsigned CntWidth = $clog2(MaxDelay + 1);

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] GateLast    = CntWidth'(GateDelay - 1);
  localparam logic [CntWidth-1:0] WakeLast    = CntWidth'(WakeDelay - 1);

  typedef enum logic [2:0] {
    ACTIVE   = 3'd0,
    DRAIN    = 3'd1,
    ISOLATED = 3'd2,
    GATED    = 3'd3,
    WAKE     = 3'd4,
    RELEASE  = 3'd5
  } state_e;

  for (genvar c = 0; c < NumClusters; c++) begin : g_cluster
    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q;
    logic                  to_set;
    logic                  all_iso, none_iso;
    logic                  isolate_q, clk_en_q, iso_done_q, timeout_q;

    assign all_iso  = &isolated_i[c*NumPorts +: NumPorts];
    assign none_iso = ~|isolated_i[c*NumPorts +: NumPorts];

    // Next-state selection; inside DRAIN, completion beats abort, and abort beats timeout.
    always_comb begin
      state_d = state_q;
      to_set  = 1'b0;
      unique case (state_q)
        ACTIVE:   if (iso_req_i[c]) state_d = DRAIN;
        DRAIN: begin
          if (all_iso) begin
            state_d = ISOLATED;
          end else if (!iso_req_i[c]) begin
            state_d = RELEASE;
          end else if ((TimeoutCycles != 0) && (cnt_q == TimeoutLast)) begin
            state_d = RELEASE;
            to_set  = 1'b1;
          end
        end
        ISOLATED: begin
          if (!iso_req_i[c]) begin
            state_d = RELEASE;
          end else if (cnt_q == GateLast) begin
            state_d = GATED;
          end
        end
        GATED:    if (!iso_req_i[c]) state_d = WAKE;
        WAKE:     if (cnt_q == WakeLast) state_d = RELEASE;
        RELEASE:  if (none_iso) state_d = ACTIVE;
        default:  state_d = ACTIVE;
      endcase
    end

    // State, dwell counter and registered outputs.
    // Outputs are decoded from the next state, so each one changes on the same edge as the state.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q    <= ACTIVE;
        cnt_q      <= '0;
        isolate_q  <= 1'b0;
        clk_en_q   <= 1'b1;
        iso_done_q <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        if (state_d != state_q) begin
          cnt_q <= '0;
        end else if (state_q inside {DRAIN, ISOLATED, WAKE}) begin
          cnt_q <= cnt_q + CntWidth'(1);
        end
        isolate_q  <= state_d inside {DRAIN, ISOLATED, GATED, WAKE};
        clk_en_q   <= (state_d != GATED);
        iso_done_q <= state_d inside {ISOLATED, GATED};
        timeout_q  <= to_set | (timeout_q & ~timeout_clr_i[c]);
      end
    end

    assign isolate_o[c*NumPorts +: NumPorts] = {NumPorts{isolate_q}};
    assign clk_en_o[c]                       = clk_en_q;
    assign iso_done_o[c]                     = iso_done_q;
    assign timeout_o[c]                      = timeout_q;
    assign state_o[3*c +: 3]                 = state_q;
  end

endmodule

// File: tb/tb_chimera_clu_iso_seq.sv
// Self-checking bench for chimera_clu_iso_seq. It contains a cycle-level
// behavioural model, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase driven by an isolation-port emulator.
module tb_chimera_clu_iso_seq;
  localparam int NC = 5;
  localparam int NP = 4;
  localparam int TO = 16;
  localparam int GD = 4;
  localparam int WD = 8;

  localparam int P_ACT = 0;
  localparam int P_DRN = 1;
  localparam int P_ISO = 2;
  localparam int P_GAT = 3;
  localparam int P_WAK = 4;
  localparam int P_REL = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req, clr;
  logic [NC*NP-1:0]  isd;
  logic [NC*NP-1:0]  isolate_o;
  logic [NC-1:0]     clk_en_o, iso_done_o, timeout_o;
  logic [3*NC-1:0]   state_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  chimera_clu_iso_seq #(
    .NumClusters  (NC),
    .NumPorts     (NP),
    .TimeoutCycles(TO),
    .GateDelay    (GD),
    .WakeDelay    (WD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .iso_req_i    (req),
    .isolated_i   (isd),
    .isolate_o    (isolate_o),
    .clk_en_o     (clk_en_o),
    .iso_done_o   (iso_done_o),
    .timeout_o    (timeout_o),
    .timeout_clr_i(clr),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase per cluster, plus the cycle stamp at which the phase was entered.
  int m_ph[NC] = '{default: 0};
  int m_since[NC] = '{default: 0};
  int n_ph[NC];
  logic [NC-1:0] m_to = '0;
  logic [NC-1:0] n_to;
  int cyc = 0;

  always_comb begin
    n_to = m_to;
    for (int c = 0; c < NC; c++) begin
      n_ph[c] = m_ph[c];
      n_to[c] = m_to[c] & ~clr[c];
      case (m_ph[c])
        P_ACT: if (req[c]) n_ph[c] = P_DRN;
        P_DRN: begin
          if (&isd[c*NP +: NP]) n_ph[c] = P_ISO;
          else if (!req[c]) n_ph[c] = P_REL;
          else if (TO != 0 && (cyc - m_since[c]) == TO - 1) begin
            n_ph[c] = P_REL;
            n_to[c] = 1'b1;
          end
        end
        P_ISO: begin
          if (!req[c]) n_ph[c] = P_REL;
          else if ((cyc - m_since[c]) == GD - 1) n_ph[c] = P_GAT;
        end
        P_GAT: if (!req[c]) n_ph[c] = P_WAK;
        P_WAK: if ((cyc - m_since[c]) == WD - 1) n_ph[c] = P_REL;
        P_REL: if (isd[c*NP +: NP] == '0) n_ph[c] = P_ACT;
        default: n_ph[c] = P_ACT;
      endcase
      if (rst) begin
        n_ph[c] = P_ACT;
        n_to[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    m_to <= n_to;
    for (int c = 0; c < NC; c++) begin
      m_ph[c] <= n_ph[c];
      if (rst || n_ph[c] != m_ph[c]) m_since[c] <= cyc + 1;
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [NC*NP-1:0] e_iso;
      logic [NC-1:0]    e_clk, e_done;
      logic [3*NC-1:0]  e_st;
      for (int c = 0; c < NC; c++) begin
        e_st[3*c +: 3] = 3'(m_ph[c]);
        e_clk[c]       = (m_ph[c] != P_GAT);
        e_done[c]      = (m_ph[c] == P_ISO) || (m_ph[c] == P_GAT);
        for (int p = 0; p < NP; p++)
          e_iso[c*NP + p] = (m_ph[c] >= P_DRN) && (m_ph[c] <= P_WAK);
      end
      chk("model_state_o",    32'(state_o),    32'(e_st));
      chk("model_isolate_o",  32'(isolate_o),  32'(e_iso));
      chk("model_clk_en_o",   32'(clk_en_o),   32'(e_clk));
      chk("model_iso_done_o", 32'(iso_done_o), 32'(e_done));
      chk("model_timeout_o",  32'(timeout_o),  32'(m_to));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] st(input int c);
    logic [3*NC-1:0] s;
    s = state_o;
    return s[3*c +: 3];
  endfunction

  logic [NC*NP-1:0] stuck;

  initial begin
    rst = 1'b1; req = '0; clr = '0; isd = '0; stuck = '0;
    step(2);
    cmp_en = 1'b1;
    chk("reset_state",   32'(state_o),    32'h0);
    chk("reset_clk_en",  32'(clk_en_o),   32'h1F);
    chk("reset_isolate", 32'(isolate_o),  32'h0);
    chk("reset_done",    32'(iso_done_o), 32'h0);
    chk("reset_timeout", 32'(timeout_o),  32'h0);
    rst = 1'b0;
    step(1);

    // Basic gate on cluster 0
    req[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 1) chk("gate_isolate_rise", 32'(isolate_o[3:0]), 32'hF);
      if (i == 5) chk("gate_still_drain", 32'(st(0)), 32'd1);
      if (i == 5) isd[3:0] = 4'hF;
      if (i == 6) chk("gate_isolated_state", 32'(st(0)), 32'd2);
      if (i == 6) chk("gate_done_rise", 32'(iso_done_o[0]), 32'd1);
      if (i == 9) chk("gate_clk_en_before", 32'(clk_en_o[0]), 32'd1);
      if (i == 10) chk("gate_clk_en_drop", 32'(clk_en_o[0]), 32'd0);
      if (i == 10) chk("gate_gated_state", 32'(st(0)), 32'd3);
    end

    // Wake cluster 0
    req[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 1) chk("wake_clk_en", 32'(clk_en_o[0]), 32'd1);
      if (i == 1) chk("wake_state", 32'(st(0)), 32'd4);
      if (i <= 8) chk("wake_isolate_held", 32'(isolate_o[3:0]), 32'hF);
      if (i == 9) chk("wake_isolate_fall", 32'(isolate_o[3:0]), 32'h0);
      if (i == 11) chk("wake_release_wait", 32'(st(0)), 32'd5);
      if (i == 11) isd[3:0] = 4'h0;
      if (i == 12) chk("wake_active", 32'(st(0)), 32'd0);
    end

    // Drain timeout on cluster 1
    isd[7:4] = 4'hE;
    req[1] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      if (i == 16) chk("to_not_yet", 32'(timeout_o[1]), 32'd0);
      if (i == 17) chk("to_set", 32'(timeout_o[1]), 32'd1);
      if (i == 17) chk("to_release", 32'(st(1)), 32'd5);
      if (i == 17) chk("to_isolate_fall", 32'(isolate_o[7:4]), 32'h0);
    end
    req[1] = 1'b0; isd[7:4] = 4'h0;
    step(1);
    chk("to_sticky", 32'(timeout_o[1]), 32'd1);
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    chk("to_cleared", 32'(timeout_o[1]), 32'd0);

    // Completion coinciding with the timeout cycle
    req[1] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      if (i == 16) isd[7:4] = 4'hF;
      if (i == 17) chk("race_isolated", 32'(st(1)), 32'd2);
      if (i == 17) chk("race_no_timeout", 32'(timeout_o[1]), 32'd0);
    end
    req[1] = 1'b0;
    step(1);
    isd[7:4] = 4'h0;
    step(1);
    chk("race_back_active", 32'(st(1)), 32'd0);

    // Clear coinciding with a new timeout
    req[1] = 1'b1; isd[7:4] = 4'hE;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      if (i == 16) clr[1] = 1'b1;
    end
    clr[1] = 1'b0;
    chk("set_beats_clear", 32'(timeout_o[1]), 32'd1);
    req[1] = 1'b0; isd[7:4] = 4'h0;
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    step(1);

    // Early abort during DRAIN on cluster 2
    req[2] = 1'b1;
    step(2);
    req[2] = 1'b0;
    step(1);
    chk("abort_drain_release", 32'(st(2)), 32'd5);
    chk("abort_drain_clk_en", 32'(clk_en_o[2]), 32'd1);
    step(1);
    chk("abort_drain_active", 32'(st(2)), 32'd0);

    // Early abort during ISOLATED on cluster 2
    req[2] = 1'b1;
    step(1);
    isd[11:8] = 4'hF;
    step(1);
    chk("abort_iso_isolated", 32'(st(2)), 32'd2);
    step(1);
    req[2] = 1'b0;
    step(1);
    chk("abort_iso_release", 32'(st(2)), 32'd5);
    chk("abort_iso_clk_en", 32'(clk_en_o[2]), 32'd1);
    isd[11:8] = 4'h0;
    step(1);
    chk("abort_iso_active", 32'(st(2)), 32'd0);

    // Reset while cluster 2 is GATED and cluster 3 is in WAKE
    req[3:2] = 2'b11; isd[15:8] = 8'hFF;
    step(6);
    chk("mid_c2_gated", 32'(st(2)), 32'd3);
    chk("mid_c3_gated", 32'(st(3)), 32'd3);
    req[3] = 1'b0;
    step(1);
    chk("mid_c3_wake", 32'(st(3)), 32'd4);
    rst = 1'b1;
    step(1);
    rst = 1'b0; req = '0; isd = '0;
    chk("mid_rst_state", 32'(state_o), 32'h0);
    chk("mid_rst_clk_en", 32'(clk_en_o), 32'h1F);
    chk("mid_rst_isolate", 32'(isolate_o), 32'h0);
    chk("mid_rst_done", 32'(iso_done_o), 32'h0);
    step(2);

    // Randomized traffic with emulated isolation ports
    for (int k = 0; k < 2500; k++) begin
      step(1);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 24) == 0) req[c] = ~req[c];
        clr[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 99) == 0)
          stuck[c*NP +: NP] = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, NP - 1)) : 4'h0;
      end
      for (int b = 0; b < NC*NP; b++) begin
        if (stuck[b]) isd[b] = 1'b0;
        else if (isd[b] != isolate_o[b] && $urandom_range(0, 2) == 0) isd[b] = isolate_o[b];
      end
    end
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chimera_clu_iso_seq.md
Name: chimera_clu_iso_seq

Overview:
- Per-cluster isolation and clock-gating sequencer for the Chimera cluster domain.
- Drives the isolate inputs of every AXI isolation port belonging to each external cluster and watches their isolated outputs.
- Gates the cluster clock once the cluster is fully quiesced, and restores clock and connectivity in order on wake-up.
- Generalises the fixed per-cluster isolate/isolated wiring to N clusters × P ports, adding drain timeout, gate and wake delays, and status reporting.

Parameters:
- NumClusters, 5, number of external clusters sequenced.
- NumPorts, 4, AXI isolation ports per cluster (narrow in, 2× narrow out, wide out); must be ≥1.
- TimeoutCycles, 1024, maximum DRAIN cycles before abort; 0 disables the timeout.
- GateDelay, 4, cycles spent in ISOLATED before clock enable drops; must be ≥1.
- WakeDelay, 8, cycles with clock enabled before isolation is released; must be ≥1.
- CntWidth, derived, $clog2(max(TimeoutCycles, GateDelay, WakeDelay)+1); not to be overridden.

Ports:
- clk_i  in  1  SoC clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- iso_req_i  in  NumClusters  level request per cluster: 1 = isolate and gate, 0 = run.
- isolated_i  in  NumClusters*NumPorts  isolated flags from the isolation ports; cluster c owns bits [c*NumPorts +: NumPorts].
- isolate_o  out  NumClusters*NumPorts  isolate commands to the isolation ports; same bit mapping as isolated_i.
- clk_en_o  out  NumClusters  cluster clock-gate enable.
- iso_done_o  out  NumClusters  cluster fully isolated (states ISOLATED or GATED).
- timeout_o  out  NumClusters  sticky drain-timeout flag.
- timeout_clr_i  in  NumClusters  clears the matching timeout_o bit.
- state_o  out  3*NumClusters  current FSM state per cluster, for debug.

Behaviour:
- One independent FSM per cluster, plus one CntWidth-bit counter per cluster. All outputs are registered.
- State encoding: ACTIVE=0, DRAIN=1, ISOLATED=2, GATED=3, WAKE=4, RELEASE=5.
- Reset (rst_i=1 at a clock edge), applied to every cluster, including mid-sequence:
  - state=ACTIVE, counter=0;
  - isolate_o=0, clk_en_o=1, iso_done_o=0, timeout_o=0.
- all_iso(c) is the AND of cluster c's isolated_i slice; none_iso(c) is the NOR of that slice.
- The counter clears on every state change.
- ACTIVE:
  - isolate=0, clk_en=1.
  - iso_req=1 → DRAIN. isolate_o for all ports of the cluster goes to 1 in the same edge the state enters DRAIN (one cycle after the request is sampled).
- DRAIN: isolate=1, counter increments each cycle. Checked in this priority order:
  1. all_iso → ISOLATED.
  2. iso_req=0 → RELEASE.
  3. TimeoutCycles≠0 and counter==TimeoutCycles-1 → set timeout_o, then RELEASE.
  - If all_iso and the timeout condition occur in the same cycle, ISOLATED wins and no timeout is flagged.
- ISOLATED:
  - iso_done=1, clk_en=1, counter increments.
  - iso_req=0 → RELEASE, with no gating performed.
  - Otherwise, when counter==GateDelay-1 → GATED.
- GATED:
  - clk_en=0, iso_done=1, isolate=1.
  - iso_req=0 → WAKE.
  - isolated_i is ignored while gated.
- WAKE:
  - clk_en=1, iso_done=0, isolate=1.
  - counter==WakeDelay-1 → RELEASE.
  - iso_req returning to 1 during WAKE is ignored until ACTIVE is reached.
- RELEASE:
  - isolate=0.
  - none_iso → ACTIVE.
  - No timeout applies. iso_req is ignored until ACTIVE is reached; a held request re-enters DRAIN on the cycle after ACTIVE.
- timeout_o:
  - Set by a drain abort; cleared by timeout_clr_i.
  - If set and clear occur in the same cycle, set wins.
- Clusters are fully independent; simultaneous requests to all clusters must sequence in parallel with identical latency.
- isolate_o, clk_en_o and iso_done_o are driven strictly from the state register, so they are glitch-free relative to the gate.

Test Plan:
- Basic gate: NumPorts=4, iso_req[0]=1 at cycle 0, isolated_i[3:0] set to 1 at cycle 5.
  - Required: isolate_o[3:0]=1 from cycle 1; ISOLATED at cycle 6; clk_en_o[0]=0 at cycle 10 with GateDelay=4; iso_done_o[0]=1 from cycle 6.
- Wake: from GATED, drop iso_req[0]; clear isolated_i two cycles after isolate_o falls.
  - Required: clk_en_o=1 the next cycle; isolate_o stays 1 for 8 cycles (WakeDelay=8); the cluster then reaches ACTIVE.
- Timeout: TimeoutCycles=16, isolated_i held at 0xE on cluster 1.
  - Required: timeout_o[1]=1 after 16 DRAIN cycles; isolate_o slice returns to 0; pulsing timeout_clr_i[1] clears the flag.
- Timeout race: all_iso and counter==TimeoutCycles-1 in the same cycle → ISOLATED, timeout_o stays 0. Separately, timeout_clr_i coinciding with a new timeout → flag remains 1.
- Early abort: iso_req dropped during DRAIN, and separately during ISOLATED before GateDelay expires.
  - Required: RELEASE in both cases; clk_en_o never drops.
- Reset mid-sequence: rst_i asserted while cluster 2 is GATED and cluster 3 is in WAKE.
  - Required: next cycle all outputs equal reset values (clk_en_o all 1, isolate_o 0, state_o all 0).
